// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory with loader bypass, NOP clear and fault flags
module instr_mem_sync #(
  parameter int              PC_W         = 16,
  parameter int              DATA_W       = 32,
  parameter int              DEPTH        = 16,
  parameter int              PC_SHIFT     = 1,
  parameter logic [DATA_W-1:0] NOP_WORD   = {DATA_W{1'b0}},
  parameter bit              CLEAR_ON_RST = 1'b1,
  parameter string           INIT_FILE    = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [PC_W-1:0]          pc,
  input  logic                     stall,
  output logic [DATA_W-1:0]        instruction,
  output logic                     instr_valid,
  output logic                     fault,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PC_W-1:0] MIS_MASK = PC_W'((1 << PC_SHIFT) - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, idx, mem_addr;
  logic [DATA_W-1:0] instr_q, instr_d, rd_word, mem_data;
  logic valid_q, valid_d, fault_q, fault_d, ready_q, ready_d;
  logic clearing, last, accept, bad, mem_we;
  always_comb begin
    idx      = AW'(pc >> PC_SHIFT);
    bad      = |(pc & MIS_MASK) | |(pc >> (PC_SHIFT + AW));
    clearing = state_q == CLEAR;
    last     = clearing && cnt_q == AW'(DEPTH - 1);
    accept   = !clearing && fetch_req && !stall;
    rd_word  = (wr_en && wr_addr == idx) ? wr_data : mem[idx];
    instr_d  = accept ? (bad ? NOP_WORD : rd_word) : instr_q;
    valid_d  = clearing ? 1'b0 : stall ? valid_q : accept;
    fault_d  = clearing ? 1'b0 : stall ? fault_q : accept && bad;
    cnt_d    = clearing ? cnt_q + 1'b1 : cnt_q;
    state_d  = last ? RUN : state_q;
    ready_d  = state_d == RUN;
    mem_we   = clearing || wr_en;
    mem_addr = clearing ? cnt_q : wr_addr;
    mem_data = clearing ? NOP_WORD : wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : RUN;
      ready_q <= !CLEAR_ON_RST;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && mem_we) mem[mem_addr] <= mem_data;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign ready       = ready_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed checks of fetch latency, bypass, faults, stall, clear and reset
module tb_instr_mem_sync;
  logic clk = 1'b0, rst = 1'b1, fetch_req = 1'b0, stall = 1'b0, wr_en = 1'b0;
  logic [15:0] pc = '0;
  logic [3:0] wr_addr = '0;
  logic [31:0] wr_data = '0, instruction;
  logic instr_valid, fault, ready;
  int tests = 0, fails = 0;
  instr_mem_sync dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .stall(stall),
    .instruction(instruction), .instr_valid(instr_valid), .fault(fault), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    fetch_req = 1'b0; stall = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask
  task automatic fetch(input logic [15:0] p);
    fetch_req = 1'b1; pc = p;
  endtask
  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    idle();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", instruction); end
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) fetch(16'h0000);
      tick();
      tests++; if (ready !== (i == 16)) begin fails++; $display("FAIL clear_ready cyc %0d got %b exp %b", i, ready, i == 16); end
      if (i == 5) begin
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL clear_ignores_fetch got %b exp 0", instr_valid); end
        idle();
      end
    end
    fetch(16'h0006);
    tick();
    idle();
    tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL first_fetch_instr got %h exp 0", instruction); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL first_fetch_valid got %b exp 1", instr_valid); end
  endtask
  task automatic test_write_bypass();
    write(4'd3, 32'h41F0_0001);
    tick();
    idle();
    fetch(16'h0006);
    tick();
    idle();
    tests++; if (instruction !== 32'h41F0_0001) begin fails++; $display("FAIL write_then_fetch got %h exp 41f00001", instruction); end
    write(4'd5, 32'hDEAD_BEEF);
    fetch(16'h000A);
    tick();
    idle();
    tests++; if (instruction !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass got %h exp deadbeef", instruction); end
    fetch(16'h000A);
    tick();
    idle();
    tests++; if (instruction !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_stored got %h exp deadbeef", instruction); end
  endtask
  task automatic test_fault();
    write(4'd15, 32'h0000_0F0F);
    tick();
    idle();
    fetch(16'h001E);
    tick();
    idle();
    tests++; if (instruction !== 32'h0000_0F0F || fault !== 1'b0) begin fails++; $display("FAIL top_word got %h/%b exp 00000f0f/0", instruction, fault); end
    fetch(16'h0003);
    tick();
    idle();
    tests++; if (fault !== 1'b1 || instruction !== 32'h0 || instr_valid !== 1'b1) begin fails++; $display("FAIL misaligned got %b/%h exp 1/0", fault, instruction); end
    fetch(16'h0020);
    write(4'd0, 32'h0000_1234);
    tick();
    idle();
    tests++; if (fault !== 1'b1 || instruction !== 32'h0) begin fails++; $display("FAIL out_of_range got %b/%h exp 1/0", fault, instruction); end
  endtask
  task automatic test_stall();
    write(4'd1, 32'h1111_1111);
    tick();
    write(4'd2, 32'h2222_2222);
    tick();
    idle();
    fetch(16'h0000);
    tick();
    tests++; if (instruction !== 32'h0000_1234 || fault !== 1'b0) begin fails++; $display("FAIL stall_pc0 got %h exp 00001234", instruction); end
    fetch(16'h0002);
    stall = 1'b1;
    write(4'd6, 32'h0000_0066);
    tick();
    stall = 1'b0; wr_en = 1'b0;
    tests++; if (instruction !== 32'h0000_1234 || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_hold got %h/%b exp 00001234/1", instruction, instr_valid); end
    tick();
    tests++; if (instruction !== 32'h1111_1111) begin fails++; $display("FAIL stall_release got %h exp 11111111", instruction); end
    fetch(16'h0004);
    tick();
    tests++; if (instruction !== 32'h2222_2222 || instr_valid !== 1'b1) begin fails++; $display("FAIL back_to_back got %h exp 22222222", instruction); end
    fetch(16'h000C);
    tick();
    idle();
    tests++; if (instruction !== 32'h0000_0066) begin fails++; $display("FAIL write_during_stall got %h exp 00000066", instruction); end
  endtask
  task automatic test_idle();
    tick();
    tests++; if (instr_valid !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL idle_valid got %b/%b exp 0/0", instr_valid, fault); end
    tests++; if (instruction !== 32'h0000_0066) begin fails++; $display("FAIL idle_hold got %h exp 00000066", instruction); end
  endtask
  task automatic test_rst_mid();
    fetch(16'h0002);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_req = 1'b0;
    tests++; if (instr_valid !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL rst_mid_fetch got %b/%b exp 0/0", instr_valid, ready); end
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      tests++; if (ready !== (i == 16)) begin fails++; $display("FAIL rst_mid_clear cyc %0d got %b exp %b", i, ready, i == 16); end
    end
    fetch(16'h0002);
    tick();
    idle();
    tests++; if (instruction !== 32'h0 || instr_valid !== 1'b1) begin fails++; $display("FAIL recleared got %h exp 0", instruction); end
  endtask
  initial begin
    test_reset();
    test_write_bypass();
    test_fault();
    test_stall();
    test_idle();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
